// File: rtl/seq_pkg.sv
// Shared definitions for the exec_sequencer slice: opcodes, instruction
// field positions and the sequencer state type.
package seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd7;

  // Instruction layout: opcode[11:9] rs1[8:6] rs2[5:3] rd[2:0]
  localparam int OPC_LSB = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int RD_LSB  = 0;
  localparam int FIELD_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } seq_state_e;

  // Opcodes that write a result back to the register file.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_XOR) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/seq_wport_arb.sv
// Register-file write-port arbiter: core writeback has priority, the host
// is granted in any other cycle. Host support is built only when
// SEQ_HOST_PORT_EN is defined; otherwise host_gnt is tied low.
module seq_wport_arb
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              rst,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

`ifdef SEQ_HOST_PORT_EN
  // Grant the host whenever the core is not writing and reset is low.
  always_comb begin
    host_gnt = host_req && !core_we && !rst;
  end
`else
  logic unused_host;
  assign unused_host = ^{host_req, host_addr, host_wdata};

  // Host path absent: never grant.
  always_comb begin
    host_gnt = 1'b0;
  end
`endif

  // Select the write source; idle port drives zeros.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (core_we) begin
      rf_we    = 1'b1;
      rf_waddr = core_waddr;
      rf_wdata = core_wdata;
    end else if (host_gnt) begin
      rf_we    = 1'b1;
      rf_waddr = host_addr;
      rf_wdata = host_wdata;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/READ/EXEC/WB control sequencer with a shared
// register-file write port. Optional host write access: SEQ_HOST_PORT_EN.
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int PC_W    = 3,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  rf_raddr1,
  output logic [ADDR_W-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic [2:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic               host_req,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               host_gnt,
  output logic               busy,
  output logic               halted,
  output logic               retired
);

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  op1_q, op1_d;
  logic [DATA_W-1:0]  op2_q, op2_d;
  logic [DATA_W-1:0]  res_q, res_d;

  logic [2:0]         opcode;
  logic               core_we;

  logic [DATA_W-PC_W-1:0] unused_op2_hi;
  assign unused_op2_hi = op2_q[DATA_W-1:PC_W];

  assign opcode = ir_q[OPC_LSB +: FIELD_W];

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem_data;
        state_d = S_READ;
      end
      S_READ: begin
        op1_d   = rf_rdata1;
        op2_d   = rf_rdata2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_result;
        state_d = (opcode == OP_HALT) ? S_HALT : S_WB;
      end
      S_WB: begin
        if ((opcode == OP_JMP) && (op1_q == '0)) pc_d = op2_q[PC_W-1:0];
        else                                     pc_d = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
    end
  end

  // State-decoded control outputs; writeback effects are suppressed while
  // rst is high so a reset in WB aborts the instruction.
  always_comb begin
    imem_addr = pc_q;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    alu_op    = '0;
    if (state_q == S_READ) begin
      rf_raddr1 = ir_q[RS1_LSB +: ADDR_W];
      rf_raddr2 = ir_q[RS2_LSB +: ADDR_W];
    end
    if (state_q == S_EXEC) alu_op = opcode;
    busy    = (state_q == S_FETCH) || (state_q == S_READ) ||
              (state_q == S_EXEC)  || (state_q == S_WB);
    halted  = (state_q == S_HALT);
    retired = (state_q == S_WB) && !rst;
    core_we = (state_q == S_WB) && is_alu_op(opcode) && !rst;
  end

  seq_wport_arb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wport_arb (
    .rst        (rst),
    .core_we    (core_we),
    .core_waddr (ir_q[RD_LSB +: ADDR_W]),
    .core_wdata (res_q),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control sequencer for the non-pipelined microprocessor. It steps each instruction through fetch, operand read, execute and writeback, and drives the program-ROM address, the two register-file read addresses, the ALU opcode and the single register-file write port. It also shares that write port with an external host loader through a request/grant handshake. It sits between the program ROM, the 8-entry data memory and the ALU, and replaces the free-running PC and combinational writeback control.

## Interface
- DATA_W, 8, data memory / ALU word width
- ADDR_W, 3, data memory address width (8 entries)
- PC_W, 3, program counter width (8 instructions)
- INSTR_W, 12, instruction width; fields are opcode[11:9], rs1[8:6], rs2[5:3], rd[2:0]

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous reset, active-high
- start  in  1  leave IDLE/HALT and begin execution at pc 0
- imem_addr  out  PC_W  program ROM address (= pc)
- imem_data  in  INSTR_W  ROM instruction, combinational from imem_addr
- rf_raddr1, rf_raddr2  out  ADDR_W  register-file read addresses
- rf_rdata1, rf_rdata2  in  DATA_W  register-file read data, combinational
- alu_op  out  3  opcode presented to the ALU
- alu_result  in  DATA_W  ALU output, combinational
- rf_we  out  1  write enable to the register file
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- host_req  in  1  host write request; held until granted
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host write performed this cycle
- busy  out  1  FSM in FETCH, READ, EXEC or WB
- halted  out  1  FSM in HALT
- retired  out  1  one-cycle pulse at the end of each WB

## Operation
- Opcodes: NOP=0, ADD=1, XOR=2, AND=3, JMP=4, HALT=7. Opcodes 5 and 6 execute as NOP.
- States: IDLE, FETCH, READ, EXEC, WB, HALT.
- IDLE: a start pulse sets pc to 0 and moves to FETCH. Otherwise the FSM stays in IDLE.
- FETCH: ir is loaded from imem_data. Next state is READ.
- READ: rf_raddr1 = ir.rs1 and rf_raddr2 = ir.rs2. op1 and op2 are latched. Next state is EXEC.
- EXEC: alu_op = ir.opcode and res is latched from alu_result.
  - If ir.opcode is HALT, the next state is HALT and pc is unchanged.
  - Otherwise the next state is WB.
- WB by opcode:
  - ADD/XOR/AND: rf_we=1, rf_waddr=ir.rd, rf_wdata=res.
  - JMP: pc ← op2[PC_W-1:0] if op1==0, else pc+1.
  - All other opcodes: pc ← pc+1, no write.
  - Arithmetic pc updates wrap modulo 2^PC_W (7→0).
  - retired=1. Next state is FETCH.
- HALT: a start pulse restarts at pc 0 via FETCH.
- Write-port arbitration:
  - The core owns the port in WB of an ALU op.
  - In every other cycle, including IDLE and HALT, host_req gets host_gnt=1 in the same cycle. rf_we=1, rf_waddr=host_addr, rf_wdata=host_wdata.
  - When the host is blocked, the worst-case wait is 1 cycle.
  - Operands are latched in READ, so a host write after READ does not affect the in-flight instruction.
- Reset values: state IDLE, pc/ir/op1/op2/res 0, all outputs 0 (rf_raddr*, alu_op included).
- rst has priority over start and over all transitions. A reset mid-instruction aborts it: no rf_we and no retired in the reset cycle.

## Timing
- 4 cycles per instruction (FETCH→READ→EXEC→WB). retired is asserted every 4th cycle while running.
- The first FETCH is the cycle after the start pulse.
- The register-file write happens at the posedge that ends WB. An instruction that reads the same register in its READ sees the new value.
- A JMP target is fetched in the FETCH immediately after WB.
- host_gnt is combinational from host_req and state, and it is never asserted while rst=1.
- The host deasserts or changes host_req in the cycle after host_gnt.

## Configuration
- SEQ_HOST_PORT_EN defined: host arbitration as above.
- Without the macro:
  - Host ports remain present, but host_gnt is tied 0 and host_req is ignored.
  - rf_we is asserted only in ALU-op WB.

## Structure
- Shared package seq_pkg holds:
  - Opcode localparams (NOP, ADD, XOR, AND, JMP, HALT).
  - The state enum typedef.
  - Instruction field bit positions.
- One sub-module, seq_wport_arb: write-port mux/arbiter between the core writeback and the host, with the grant logic.

## Test plan
- Reset then start, ROM = {ADD r0←r1+r2 with r1=3, r2=4; HALT} → r0=7 at the end of cycle 4, retired once, then halted=1 and busy=0.
- JMP with op1=0 and op2=8'h05 → next imem_addr=5. JMP with op1=1 → imem_addr=pc+1.
- NOP at pc 7 → pc wraps to 0 and the next fetch is address 0.
- host_req held from a WB cycle of an ADD → host_gnt=0 in WB, host_gnt=1 in the following FETCH, host data written, and the core result still written in WB.
- rst asserted during EXEC of an ADD → no rf_we, all outputs 0 next cycle, state IDLE, and start restarts at pc 0.
- Build without SEQ_HOST_PORT_EN, host_req=1 in IDLE → host_gnt=0 and rf_we=0.
